// File: rtl/cmp_stim_pkg.sv
// Shared types and the fixed vector table for the comparator stimulus generator.
// Vector i drives a=VEC_A[i], b=VEC_B[i] and expects equal=VEC_EXP[i].
package cmp_stim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int NUM_VEC = 5;

   // Bit i of each mask belongs to vector i: (0,0,1) (0,1,0) (1,1,1) (1,0,0) (0,0,1)
   localparam logic [NUM_VEC-1:0] VEC_A   = 5'b01100;
   localparam logic [NUM_VEC-1:0] VEC_B   = 5'b00110;
   localparam logic [NUM_VEC-1:0] VEC_EXP = 5'b10101;

   localparam logic [2:0] FIRST_IDX = 3'd0;
   localparam logic [2:0] LAST_IDX  = 3'(NUM_VEC - 1);

   function automatic logic vecA(input logic [2:0] idx);
      return VEC_A[idx];
   endfunction

   function automatic logic vecB(input logic [2:0] idx);
      return VEC_B[idx];
   endfunction

   function automatic logic vecExp(input logic [2:0] idx);
      return VEC_EXP[idx];
   endfunction

endpackage

// File: rtl/cmp_stim_gen_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while enabled and flags the
// last clock of each hold with tc, wrapping back to zero instead of overrunning.
module hold_timer #(
   parameter int HOLD_CYCLES = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   assign tc = (r_count == TC_VAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= tc ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/cmp_stim_gen.sv
// Self-timed stimulus generator for the 1-bit equality comparator: plays the
// five-vector table on a/b, samples equal at the end of each hold, counts misses.
module cmp_stim_gen #(
   parameter int HOLD_CYCLES = 100,
   parameter int ERR_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic             equal,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [2:0]       vec_idx
);

   import cmp_stim_pkg::*;

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_a;
   logic             r_b;
   logic [2:0]       r_vecIdx;
   logic [ERR_W-1:0] r_errCnt;

   logic             w_timerTc;
   logic             w_timerClr;
   logic             w_timerEn;
   logic             w_launch;
   logic             w_sample;
   logic             w_lastVec;
   logic             w_mismatch;
   logic [2:0]       w_nextIdx;

   hold_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_holdTimer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_timerClr),
      .en    (w_timerEn),
      .tc    (w_timerTc)
   );

   assign w_lastVec  = (r_vecIdx == LAST_IDX);
   assign w_nextIdx  = r_vecIdx + 3'd1;
   assign w_mismatch = (equal != vecExp(r_vecIdx));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // start is only honoured outside RUN, so a stray pulse never restarts a sequence
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, FIN: begin
            if (start) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (w_timerTc && w_lastVec) begin
               w_nextState = FIN;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_launch   = 1'b0;
      w_sample   = 1'b0;
      w_timerClr = 1'b0;
      w_timerEn  = 1'b0;
      case (r_state)
         IDLE, FIN: begin
            w_launch   = start;
            w_timerClr = start;
         end
         RUN: begin
            w_timerEn = 1'b1;
            w_sample  = w_timerTc;
         end
         default: begin
            w_launch = 1'b0;
         end
      endcase
   end

   // a/b are registered so the comparator sees clean edges; they park at 0/0 in FIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= 1'b0;
         r_b      <= 1'b0;
         r_vecIdx <= FIRST_IDX;
      end else if (w_launch) begin
         r_a      <= vecA(FIRST_IDX);
         r_b      <= vecB(FIRST_IDX);
         r_vecIdx <= FIRST_IDX;
      end else if (w_sample) begin
         if (w_lastVec) begin
            r_a <= 1'b0;
            r_b <= 1'b0;
         end else begin
            r_a      <= vecA(w_nextIdx);
            r_b      <= vecB(w_nextIdx);
            r_vecIdx <= w_nextIdx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_errCnt <= '0;
      end else if (w_launch) begin
         r_errCnt <= '0;
      end else if (w_sample && w_mismatch && (r_errCnt != ERR_MAX)) begin
         r_errCnt <= r_errCnt + 1'b1;
      end
   end

   assign a       = r_a;
   assign b       = r_b;
   assign busy    = (r_state == RUN);
   assign done    = (r_state == FIN);
   assign pass    = done && (r_errCnt == '0);
   assign err_cnt = r_errCnt;
   assign vec_idx = r_vecIdx;

endmodule

// File: tb/tb_cmp_stim_gen.sv
// Scoreboard bench for cmp_stim_gen: a comparator model with selectable faults
// feeds equal; expected run results are queued at start and checked by a monitor.
module tb_cmp_stim_gen;

   localparam int HOLD    = 4;
   localparam int ERR_W   = 4;
   localparam int HOLD1   = 2;
   localparam int SEQ_LEN = 5 * HOLD;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             equal;
   logic             a;
   logic             b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [2:0]       vec_idx;

   logic             start1;
   logic             equal1;
   logic             a1;
   logic             b1;
   logic             busy1;
   logic             done1;
   logic             pass1;
   logic [0:0]       err1;
   logic [2:0]       vec1;

   int nCompared   = 0;
   int nMismatched = 0;
   int cyc         = 0;
   int mode        = 0;

   int tblA [5] = '{0, 0, 1, 1, 0};
   int tblB [5] = '{0, 1, 1, 0, 0};

   typedef struct {
      int startCyc;
      int expErr;
      int mode;
   } run_t;

   run_t sbq [$];

   logic d1 = 1'b0;
   logic d2 = 1'b0;

   cmp_stim_gen #(
      .HOLD_CYCLES(HOLD),
      .ERR_W      (ERR_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .equal   (equal),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .err_cnt (err_cnt),
      .vec_idx (vec_idx)
   );

   cmp_stim_gen #(
      .HOLD_CYCLES(HOLD1),
      .ERR_W      (1)
   ) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start1),
      .a       (a1),
      .b       (b1),
      .equal   (equal1),
      .busy    (busy1),
      .done    (done1),
      .pass    (pass1),
      .err_cnt (err1),
      .vec_idx (vec1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Comparator under test: 0 ideal, 1 stuck-1, 2 stuck-0, 3 ideal but 2 clocks late, 4 inverted
   always @(posedge clk) begin
      d1 <= ~(a ^ b);
      d2 <= d1;
   end

   always_comb begin
      equal = ~(a ^ b);
      case (mode)
         1: equal = 1'b1;
         2: equal = 1'b0;
         3: equal = d2;
         4: equal = a ^ b;
         default: equal = ~(a ^ b);
      endcase
   end

   function automatic int modelErr(input int m, input int w);
      int count;
      int maxVal;
      bit want;
      bit seen;
      count = 0;
      for (int i = 0; i < 5; i++) begin
         want = (tblA[i] == tblB[i]);
         case (m)
            1:       seen = 1'b1;
            2:       seen = 1'b0;
            4:       seen = !want;
            default: seen = want;
         endcase
         if (seen != want) count++;
      end
      maxVal = (1 << w) - 1;
      return (count > maxVal) ? maxVal : count;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Called just after a falling edge while the DUT is idle or finished
   task automatic applyStimulus(input int m, input int pulseLen, input bit extraStart);
      run_t r;
      mode       = m;
      r.startCyc = cyc + 1;
      r.expErr   = modelErr(m, ERR_W);
      r.mode     = m;
      sbq.push_back(r);
      start = 1'b1;
      repeat (pulseLen) @(negedge clk);
      start = 1'b0;
      if (extraStart) begin
         repeat (5) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic waitDrain(input int bound);
      int n;
      n = 0;
      while (sbq.size() > 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      checkOutput("runs outstanding", sbq.size(), 0);
      sbq.delete();
   endtask

   // Monitor: follows the oldest queued run cycle by cycle and scores it when done rises
   initial begin : monitor
      logic prevDone;
      int   k;
      int   v;
      run_t r;
      prevDone = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (sbq.size() > 0) begin
               k = cyc - sbq[0].startCyc;
               if (k >= 0 && k < SEQ_LEN) begin
                  v = k / HOLD;
                  checkOutput("a during run", int'(a), tblA[v]);
                  checkOutput("b during run", int'(b), tblB[v]);
                  checkOutput("vec_idx during run", int'(vec_idx), v);
                  checkOutput("busy during run", int'(busy), 1);
                  checkOutput("done during run", int'(done), 0);
               end
            end
            if (done && !prevDone) begin
               if (sbq.size() == 0) begin
                  checkOutput("unexpected done", 1, 0);
               end else begin
                  r = sbq.pop_front();
                  checkOutput("done latency", cyc - r.startCyc, SEQ_LEN);
                  checkOutput("err_cnt at done", int'(err_cnt), r.expErr);
                  checkOutput("pass at done", int'(pass), (r.expErr == 0) ? 1 : 0);
                  checkOutput("busy at done", int'(busy), 0);
                  checkOutput("vec_idx at done", int'(vec_idx), 4);
                  checkOutput("a at done", int'(a), 0);
                  checkOutput("b at done", int'(b), 0);
               end
            end
         end
         prevDone = done;
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int  s;
      int  n;
      bit  sawDone;
      rst_n  = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      equal1 = 1'b1;
      #1;
      checkOutput("reset a", int'(a), 0);
      checkOutput("reset b", int'(b), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset done", int'(done), 0);
      checkOutput("reset pass", int'(pass), 0);
      checkOutput("reset err_cnt", int'(err_cnt), 0);
      checkOutput("reset vec_idx", int'(vec_idx), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: ideal, stuck-1, stuck-0 restarted from FIN, late settle, inverted
      for (int m = 0; m < 5; m++) begin
         applyStimulus(m, 1, 1'b0);
         waitDrain(SEQ_LEN + 10);
      end

      // Extra start mid-run is ignored; start held high in FIN launches on the next edge
      applyStimulus(0, 1, 1'b1);
      waitDrain(SEQ_LEN + 10);
      applyStimulus(1, 3, 1'b0);
      checkOutput("pass dropped on restart", int'(pass), 0);
      waitDrain(SEQ_LEN + 10);

      for (int i = 0; i < 20; i++) begin
         applyStimulus($urandom_range(0, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
         waitDrain(SEQ_LEN + 10);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Asynchronous reset in the middle of vector 2 aborts the run
      applyStimulus(1, 1, 1'b0);
      repeat (2 * HOLD) @(negedge clk);
      checkOutput("vec_idx before abort", int'(vec_idx), 2);
      checkOutput("err_cnt before abort", int'(err_cnt), 1);
      #2;
      rst_n = 1'b0;
      sbq.delete();
      #1;
      checkOutput("abort a", int'(a), 0);
      checkOutput("abort b", int'(b), 0);
      checkOutput("abort busy", int'(busy), 0);
      checkOutput("abort err_cnt", int'(err_cnt), 0);
      checkOutput("abort vec_idx", int'(vec_idx), 0);
      @(negedge clk);
      rst_n   = 1'b1;
      sawDone = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done) sawDone = 1'b1;
      end
      checkOutput("no done after abort", int'(sawDone), 0);
      applyStimulus(0, 1, 1'b0);
      waitDrain(SEQ_LEN + 10);

      // One-bit error counter with a stuck-1 comparator: two misses saturate at 1
      start1 = 1'b1;
      s      = cyc + 1;
      @(negedge clk);
      start1 = 1'b0;
      n      = 0;
      while (!done1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("narrow done seen", int'(done1), 1);
      checkOutput("narrow done latency", cyc - s, 5 * HOLD1);
      checkOutput("narrow err_cnt saturated", int'(err1), 1);
      checkOutput("narrow pass", int'(pass1), 0);
      checkOutput("narrow busy", int'(busy1), 0);
      checkOutput("narrow vec_idx", int'(vec1), 4);
      checkOutput("narrow a", int'(a1), 0);
      checkOutput("narrow b", int'(b1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
